bcd_scan_scheduler: RTL and testbench

BCD_SCAN_SCHEDULER -- requirements
Module: bcd_scan_scheduler

---
 rtl/bcd_scan_pkg.sv | 21 ++
 rtl/bcd_scan_scheduler_if.sv | 33 +++
 rtl/bcd_dabble_step.sv | 26 ++
 rtl/bcd_scan_scheduler.sv | 117 +++++++++++
 tb/tb_bcd_scan_scheduler.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/bcd_scan_pkg.sv
// Shared constants and FSM encoding for the BCD scan scheduler.
//   SCAN_N_CH : default number of channels scanned per pass
//   SCAN_W    : default binary sample width
//   DIGIT_W   : bits per BCD digit
//   N_DIGITS  : BCD digits produced per conversion
package bcd_scan_pkg;

  localparam int unsigned SCAN_N_CH = 13;
  localparam int unsigned SCAN_W    = 12;
  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned N_DIGITS  = 4;
  localparam int unsigned CHAIN_W   = DIGIT_W * N_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_OUT   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/bcd_scan_scheduler_if.sv
// Channel mux / BCD result bus of the scan scheduler.
//   master : drives start, auto_mode, ch_data; observes results
//   slave  : the scheduler; drives ch_sel, bcd0..bcd3, bcd_ch, bcd_valid, busy, done
interface bcd_scan_scheduler_if
  import bcd_scan_pkg::*;
#(
  parameter int W = SCAN_W
);

  logic               start;
  logic               auto_mode;
  logic [3:0]         ch_sel;
  logic [W-1:0]       ch_data;
  logic [DIGIT_W-1:0] bcd0;
  logic [DIGIT_W-1:0] bcd1;
  logic [DIGIT_W-1:0] bcd2;
  logic [DIGIT_W-1:0] bcd3;
  logic [3:0]         bcd_ch;
  logic               bcd_valid;
  logic               busy;
  logic               done;

  modport master (
    output start, auto_mode, ch_data,
    input  ch_sel, bcd0, bcd1, bcd2, bcd3, bcd_ch, bcd_valid, busy, done
  );

  modport slave (
    input  start, auto_mode, ch_data,
    output ch_sel, bcd0, bcd1, bcd2, bcd3, bcd_ch, bcd_valid, busy, done
  );

endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit above 4, then shift the
// digit chain left by one, taking bit_in as the new LSB.
//   digits_in  : current BCD digit chain (digit 0 in the LSBs)
//   bit_in     : next binary bit, MSB first
//   digits_out : updated digit chain
module bcd_dabble_step
  import bcd_scan_pkg::*;
(
  input  logic [CHAIN_W-1:0] digits_in,
  input  logic               bit_in,
  output logic [CHAIN_W-1:0] digits_out
);

  logic [CHAIN_W-1:0] adj;

  always_comb begin
    adj = digits_in;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (digits_in[d*DIGIT_W +: DIGIT_W] > 4'd4)
        adj[d*DIGIT_W +: DIGIT_W] = digits_in[d*DIGIT_W +: DIGIT_W] + 4'd3;
    end
  end

  assign digits_out = {adj[CHAIN_W-2:0], bit_in};

endmodule

// File: rtl/bcd_scan_scheduler.sv
// Scans N_CH channels through an external mux and converts each W-bit sample
// to 4 BCD digits with a serial double-dabble, one bit per cycle.
//   clk, rst_n : system clock, async active-low reset
//   bus        : slave side of bcd_scan_scheduler_if (start/auto_mode/ch_data in,
//                ch_sel, bcd0..bcd3, bcd_ch, bcd_valid, busy, done out)
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | latch sample of ch_sel, clear digits, arm bit counter
// SHIFT | W double-dabble iterations, MSB first
// OUT   | results visible with bcd_valid; advance channel or end pass
module bcd_scan_scheduler
  import bcd_scan_pkg::*;
#(
  parameter int N_CH = SCAN_N_CH,
  parameter int W    = SCAN_W
)(
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_scan_scheduler_if.slave  bus
);

  localparam int         CNT_W    = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W - 1);
  localparam logic [3:0] LAST_CH  = 4'(N_CH - 1);

  scan_state_t        state, state_nx;
  logic [3:0]         ch_sel;
  logic [W-1:0]       sreg;
  logic [CHAIN_W-1:0] digits;
  logic [CHAIN_W-1:0] step_out;
  logic [CNT_W-1:0]   cnt;
  logic [CHAIN_W-1:0] bcd_q;
  logic [3:0]         bcd_ch;
  logic               bcd_valid;
  logic               busy;
  logic               done;

  bcd_dabble_step u_step (
    .digits_in  (digits),
    .bit_in     (sreg[W-1]),
    .digits_out (step_out)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_SHIFT;
      ST_SHIFT: if (cnt == '0) state_nx = ST_OUT;
      ST_OUT: begin
        if (ch_sel != LAST_CH)  state_nx = ST_LOAD;
        else if (bus.auto_mode) state_nx = ST_LOAD;
        else                    state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Results are captured on the edge that enters OUT, so bcd_valid and done
  // are high during the OUT cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_sel    <= '0;
      sreg      <= '0;
      digits    <= '0;
      cnt       <= '0;
      bcd_q     <= '0;
      bcd_ch    <= '0;
      bcd_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= (state_nx != ST_IDLE);
      case (state)
        ST_IDLE: if (bus.start) ch_sel <= '0;
        ST_LOAD: begin
          sreg   <= bus.ch_data;
          digits <= '0;
          cnt    <= CNT_INIT;
        end
        ST_SHIFT: begin
          digits <= step_out;
          sreg   <= sreg << 1;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            bcd_q     <= step_out;
            bcd_ch    <= ch_sel;
            bcd_valid <= 1'b1;
            done      <= (ch_sel == LAST_CH);
          end
        end
        ST_OUT: ch_sel <= (ch_sel == LAST_CH) ? 4'd0 : ch_sel + 4'd1;
        default: ;
      endcase
    end
  end

  assign bus.ch_sel    = ch_sel;
  assign bus.bcd0      = bcd_q[0*DIGIT_W +: DIGIT_W];
  assign bus.bcd1      = bcd_q[1*DIGIT_W +: DIGIT_W];
  assign bus.bcd2      = bcd_q[2*DIGIT_W +: DIGIT_W];
  assign bus.bcd3      = bcd_q[3*DIGIT_W +: DIGIT_W];
  assign bus.bcd_ch    = bcd_ch;
  assign bus.bcd_valid = bcd_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_bcd_scan_scheduler.sv
// Self-checking bench for bcd_scan_scheduler: timeline reference model of a
// scan pass plus decimal-arithmetic model of the conversion.
module tb_bcd_scan_scheduler;

  localparam int N_CH     = 13;
  localparam int W        = 12;
  localparam int CH_CYC   = W + 2;
  localparam int PASS_CYC = N_CH * CH_CYC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_scan_scheduler_if #(.W(W)) bus();

  bcd_scan_scheduler #(.N_CH(N_CH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [W-1:0] chan_val [16];
  assign bus.ch_data = chan_val[bus.ch_sel];

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_hold;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [19:0] obs_hold();
    return {bus.bcd_ch, bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq(tag, {bus.ch_sel, obs_hold(), bus.bcd_valid, bus.busy, bus.done}, 32'd0);
  endtask

  task automatic check_idle(input int n_cyc);
    for (int k = 0; k < n_cyc; k++) begin
      @(negedge clk);
      check_eq("idle_ctrl", {bus.busy, bus.done, bus.bcd_valid, bus.ch_sel}, 32'd0);
      check_eq("idle_hold", obs_hold(), exp_hold);
    end
  endtask

  // One or more passes starting from a start pulse; cycle 1 is the first LOAD.
  task automatic run_scan(input int n_pass, input bit auto_first, input int repulse_at,
                          input int abort_at);
    int  total;
    bit  aborted;
    total   = n_pass * PASS_CYC;
    aborted = 1'b0;
    @(negedge clk);
    bus.auto_mode = auto_first;
    bus.start     = 1'b1;
    for (int i = 1; i <= total; i++) begin
      int ip, c, p;
      bit exp_v;
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == repulse_at) bus.start = 1'b1;
      if (i == repulse_at + 1) bus.start = 1'b0;
      if (n_pass > 1 && i == PASS_CYC + 50) bus.auto_mode = 1'b0;
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        exp_hold = '0;
        check_all_zero("abort_reset");
        aborted = 1'b1;
        break;
      end
      ip    = (i - 1) % PASS_CYC;
      c     = ip / CH_CYC;
      p     = ip % CH_CYC;
      exp_v = (p == CH_CYC - 1);
      check_eq("busy", bus.busy, 1);
      check_eq("ch_sel", bus.ch_sel, c);
      check_eq("bcd_valid", bus.bcd_valid, exp_v);
      check_eq("done", bus.done, (exp_v && c == N_CH - 1));
      if (exp_v) begin
        exp_hold = {4'(c), to_bcd(int'(chan_val[c]))};
        if (chan_val[c] == 12'd4095)
          check_eq("max_4095", {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0}, 16'h4095);
      end
      check_eq("bcd_hold", obs_hold(), exp_hold);
    end
    if (!aborted) begin
      @(negedge clk);
      check_eq("end_busy", bus.busy, 0);
      check_eq("end_strobes", {bus.done, bus.bcd_valid, bus.ch_sel}, 0);
      check_eq("end_hold", obs_hold(), exp_hold);
      check_idle(5);
    end
  endtask

  task automatic randomize_channels();
    for (int k = 0; k < 16; k++) chan_val[k] = W'($urandom_range(0, 4095));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.auto_mode = 1'b0;
    exp_hold      = '0;
    for (int k = 0; k < 16; k++) chan_val[k] = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    check_idle(3);

    // all channels zero
    run_scan(1, 1'b0, 0, 0);

    // boundary values, stray start mid-pass
    randomize_channels();
    chan_val[0] = 12'd4095;
    chan_val[1] = 12'd1000;
    chan_val[2] = 12'd999;
    chan_val[7] = 12'd4095;
    run_scan(1, 1'b0, 50, 0);

    // back-to-back passes in auto mode; auto_mode dropped during second pass
    randomize_channels();
    run_scan(2, 1'b1, 0, 0);

    // reset mid-pass, then a clean pass from channel 0
    randomize_channels();
    run_scan(1, 1'b0, 0, 100);
    repeat (2) begin
      @(negedge clk);
      check_all_zero("in_reset");
    end
    rst_n = 1'b1;
    check_idle(20);
    randomize_channels();
    chan_val[12] = 12'd4095;
    run_scan(1, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
